// File: rtl/axi_mem_responder_static.sv
// AXI4 slave terminating in a DEPTH-word dual-port memory; B one cycle after wlast, first R two cycles after AR.
// R beats sit in a 2-entry buffer so rready stalls never lose data; AXI_RESP_ERR_EN adds range/length SLVERR.

// Small generic FIFO: registered storage, combinational head, push and pop allowed in the same cycle.
module axi_mem_responder_static_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= bump(wptr);
      if (pop)  rptr <= bump(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wptr] <= din;
  end

  assign dout  = store[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

module axi_mem_responder_static #(
  parameter int AXI_ID_BITS   = 4,
  parameter int ID_BITS       = AXI_ID_BITS,
  parameter int AXI_DATA_BITS = 512,
  parameter int AXI_ADDR_BITS = 32,
  parameter int DEPTH         = 1024,
  parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ID_BITS-1:0]         s_axi_awid,
  input  logic [AXI_ADDR_BITS-1:0]   s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  input  logic                       s_axi_awlock,
  input  logic [3:0]                 s_axi_awcache,
  input  logic [2:0]                 s_axi_awprot,
  input  logic [3:0]                 s_axi_awqos,
  input  logic [3:0]                 s_axi_awregion,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXI_DATA_BITS-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_BITS/8-1:0] s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [ID_BITS-1:0]         s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ID_BITS-1:0]         s_axi_arid,
  input  logic [AXI_ADDR_BITS-1:0]   s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arlock,
  input  logic [3:0]                 s_axi_arcache,
  input  logic [2:0]                 s_axi_arprot,
  input  logic [3:0]                 s_axi_arqos,
  input  logic [3:0]                 s_axi_arregion,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [ID_BITS-1:0]         s_axi_rid,
  output logic [AXI_DATA_BITS-1:0]   s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready
);
  localparam int STRB_BITS = AXI_DATA_BITS / 8;
  localparam int OFFS      = $clog2(STRB_BITS);
  localparam int WAW       = $clog2(DEPTH);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_BURST}        rstate_t;

  logic [AXI_DATA_BITS-1:0] mem [DEPTH];

  // The extra top bit of each difference is the borrow: address below BASE_ADDR.
  logic [AXI_ADDR_BITS:0]   aw_diff;
  logic [AXI_ADDR_BITS:0]   ar_diff;
  logic [AXI_ADDR_BITS-1:0] aw_word_full;
  logic [AXI_ADDR_BITS-1:0] ar_word_full;
  logic                     aw_err;
  logic                     ar_err;

  assign aw_diff      = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
  assign ar_diff      = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
  assign aw_word_full = aw_diff[AXI_ADDR_BITS-1:0] >> OFFS;
  assign ar_word_full = ar_diff[AXI_ADDR_BITS-1:0] >> OFFS;

`ifdef AXI_RESP_ERR_EN
  localparam logic [AXI_ADDR_BITS-1:0] DEPTH_W = AXI_ADDR_BITS'(DEPTH);
  logic [AXI_ADDR_BITS-1:0] aw_last_full;
  logic [AXI_ADDR_BITS-1:0] ar_last_full;

  assign aw_last_full = aw_word_full + ((s_axi_awburst == BURST_FIXED) ? '0 :
                        {{(AXI_ADDR_BITS-8){1'b0}}, s_axi_awlen});
  assign ar_last_full = ar_word_full + ((s_axi_arburst == BURST_FIXED) ? '0 :
                        {{(AXI_ADDR_BITS-8){1'b0}}, s_axi_arlen});
  assign aw_err = aw_diff[AXI_ADDR_BITS] || (aw_last_full >= DEPTH_W);
  assign ar_err = ar_diff[AXI_ADDR_BITS] || (ar_last_full >= DEPTH_W);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  logic unused;
  assign unused = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                    s_axi_awregion, s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                    s_axi_arqos, s_axi_arregion, aw_diff[AXI_ADDR_BITS], ar_diff[AXI_ADDR_BITS],
                    aw_word_full[AXI_ADDR_BITS-1:WAW], ar_word_full[AXI_ADDR_BITS-1:WAW]};

  // ---------------- write channel ----------------
  wstate_t          wstate, wstate_nxt;
  logic             aw_rdy, w_rdy, b_vld;
  logic             aw_hs, w_hs, mem_we;
  logic [ID_BITS-1:0] w_id;
  logic [WAW-1:0]   w_word;
  logic [7:0]       w_len;
  logic             w_fixed;
  logic [8:0]       w_cnt;
  logic             w_err;

  always_ff @(posedge aclk) begin
    if (areset) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    case (wstate)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (s_axi_awvalid) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi_bready) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  assign s_axi_awready = aw_rdy & ~areset;
  assign s_axi_wready  = w_rdy & ~areset;
  assign s_axi_bvalid  = b_vld & ~areset;
  assign s_axi_bid     = s_axi_bvalid ? w_id : '0;
  assign s_axi_bresp   = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign mem_we = w_hs && (w_cnt <= {1'b0, w_len}) && !w_err;

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_id    <= '0;
      w_word  <= '0;
      w_len   <= '0;
      w_fixed <= 1'b0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi_awid;
      w_word  <= aw_word_full[WAW-1:0];
      w_len   <= s_axi_awlen;
      w_fixed <= (s_axi_awburst == BURST_FIXED);
      w_cnt   <= '0;
      w_err   <= aw_err;
    end else if (w_hs) begin
      if (!w_fixed)     w_word <= w_word + 1'b1;
      if (w_cnt != '1)  w_cnt  <= w_cnt + 1'b1;
`ifdef AXI_RESP_ERR_EN
      if (s_axi_wlast && (w_cnt != {1'b0, w_len})) w_err <= 1'b1;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (s_axi_wstrb[b]) mem[w_word][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t            rstate, rstate_nxt;
  logic               ar_rdy;
  logic               ar_hs, r_issue, r_pop;
  logic [ID_BITS-1:0] r_id;
  logic [WAW-1:0]     r_word;
  logic [7:0]         r_len;
  logic               r_fixed;
  logic [8:0]         r_cnt;
  logic               r_err;
  logic [AXI_DATA_BITS-1:0] rd_dat;
  logic [AXI_DATA_BITS+1:0] buf_din, buf_dout;
  logic               buf_empty, buf_full;
  logic               head_last, head_err;
  logic [AXI_DATA_BITS-1:0] head_dat;

  always_ff @(posedge aclk) begin
    if (areset) rstate <= R_IDLE;
    else        rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    ar_rdy     = 1'b0;
    case (rstate)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (s_axi_arvalid) rstate_nxt = R_BURST;
      end
      R_BURST: begin
        if (r_pop && head_last) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign s_axi_arready = ar_rdy & ~areset;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign r_pop         = s_axi_rvalid & s_axi_rready;
  // A slot is free next edge if the buffer is not full or the head leaves this cycle.
  assign r_issue = (rstate == R_BURST) && !areset && (r_cnt <= {1'b0, r_len}) &&
                   (!buf_full || r_pop);

  assign rd_dat  = r_err ? '0 : mem[r_word];
  assign buf_din = {rd_dat, (r_cnt == {1'b0, r_len}), r_err};

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id    <= '0;
      r_word  <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= s_axi_arid;
      r_word  <= ar_word_full[WAW-1:0];
      r_len   <= s_axi_arlen;
      r_fixed <= (s_axi_arburst == BURST_FIXED);
      r_cnt   <= '0;
      r_err   <= ar_err;
    end else if (r_issue) begin
      if (!r_fixed) r_word <= r_word + 1'b1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  axi_mem_responder_static_fifo #(
    .WIDTH (AXI_DATA_BITS + 2),
    .DEPTH (2)
  ) u_rbuf (
    .clk   (aclk),
    .rst   (areset),
    .push  (r_issue),
    .din   (buf_din),
    .pop   (r_pop),
    .dout  (buf_dout),
    .empty (buf_empty),
    .full  (buf_full)
  );

  assign {head_dat, head_last, head_err} = buf_dout;

  assign s_axi_rvalid = !buf_empty && !areset;
  assign s_axi_rdata  = s_axi_rvalid ? head_dat : '0;
  assign s_axi_rid    = s_axi_rvalid ? r_id : '0;
  assign s_axi_rlast  = s_axi_rvalid & head_last;
  assign s_axi_rresp  = (s_axi_rvalid && head_err) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_mem_responder_static.sv
// Directed bench for axi_mem_responder_static: reset, bursts, strobes, backpressure, FIXED, collisions, range.
module tb_axi_mem_responder_static;
  localparam int IDB = 4;
  localparam int DB  = 512;
  localparam int SB  = 64;
  localparam int AB  = 32;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [IDB-1:0] awid = '0;
  logic [AB-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [1:0]    awburst = INCR;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DB-1:0] wdata = '0;
  logic [SB-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IDB-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [IDB-1:0] arid = '0;
  logic [AB-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [1:0]    arburst = INCR;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [IDB-1:0] rid;
  logic [DB-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0]  wb_dat  [0:31];
  logic [SB-1:0]  wb_strb [0:31];
  logic [DB-1:0]  rb_dat  [0:31];
  logic           rb_last [0:31];
  logic [1:0]     rb_resp [0:31];
  logic [IDB-1:0] rb_id   [0:31];

  always #5 aclk = ~aclk;

  axi_mem_responder_static #(
    .AXI_ID_BITS(IDB), .AXI_DATA_BITS(DB), .AXI_ADDR_BITS(AB), .DEPTH(1024)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd6),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd6),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one AW + nbeats W beats from wb_*; holds bready low for bhold cycles.
  task automatic do_write(input logic [IDB-1:0] id, input logic [AB-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int bhold,
                          output logic [IDB-1:0] got_bid, output logic [1:0] got_bresp,
                          output int blat, output int bstab_err, output int tmo);
    int c;
    tmo = 0;
    bstab_err = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    c = 0;
    while (!awready && c < 100) begin tick(); c++; end
    if (!awready) tmo++;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wb_dat[i]; wstrb = wb_strb[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      c = 0;
      while (!wready && c < 100) begin tick(); c++; end
      if (!wready) tmo++;
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    blat = 1;
    while (!bvalid && blat < 100) begin tick(); blat++; end
    if (!bvalid) tmo++;
    got_bid = bid;
    got_bresp = bresp;
    for (int i = 0; i < bhold; i++) begin
      tick();
      if (!bvalid || bid !== got_bid || bresp !== got_bresp) bstab_err++;
    end
    bready = 1'b1;
    tick();
    bready = 0;
  endtask

  // One AR burst; toggle!=0 drives rready with the repeating pattern 1,0,0,1.
  task automatic do_read(input logic [IDB-1:0] id, input logic [AB-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int toggle, output int nbeats,
                         output int first_lat, output int stab_err, output int tmo);
    int c, lat, k;
    logic stalled;
    logic [DB-1:0] sv_dat;
    logic [IDB-1:0] sv_id;
    logic sv_last;
    logic [1:0] sv_resp;
    tmo = 0; stab_err = 0; nbeats = 0; first_lat = 0; stalled = 1'b0;
    sv_dat = '0; sv_id = '0; sv_last = 1'b0; sv_resp = '0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    c = 0;
    while (!arready && c < 100) begin tick(); c++; end
    if (!arready) tmo++;
    tick();
    arvalid = 1'b0;
    lat = 1;
    k = 0;
    while (nbeats < int'(len) + 1 && k < 500) begin
      rready = (toggle != 0) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (rvalid) begin
        if (first_lat == 0) first_lat = lat;
        if (stalled && (rdata !== sv_dat || rid !== sv_id || rlast !== sv_last || rresp !== sv_resp))
          stab_err++;
        if (rready) begin
          if (nbeats < 32) begin
            rb_dat[nbeats] = rdata; rb_last[nbeats] = rlast;
            rb_resp[nbeats] = rresp; rb_id[nbeats] = rid;
          end
          nbeats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sv_dat = rdata; sv_id = rid; sv_last = rlast; sv_resp = rresp;
        end
      end else if (stalled) begin
        stab_err++;
      end
      tick();
      lat++;
      k++;
    end
    if (nbeats < int'(len) + 1) tmo++;
    rready = 1'b0;
  endtask

  // AW/W and AR launched so the W beat and the read issue land in chosen relative cycles.
  task automatic wr_rd_race(input logic [AB-1:0] addr, input logic [DB-1:0] d, input int ar_delay,
                            output logic [DB-1:0] got, output int seen);
    int c;
    awid = '0; awaddr = addr; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
    wdata = d; wstrb = '1; wlast = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    arid = '0; araddr = addr; arlen = 8'd0; arburst = INCR; arvalid = (ar_delay == 0);
    tick();
    awvalid = 1'b0;
    arvalid = (ar_delay != 0);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    c = 0;
    while (!rvalid && c < 10) begin tick(); c++; end
    seen = int'(rvalid);
    got = rdata;
    tick();
    tick();
    rready = 1'b0;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; awvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hs cyc%0d: got %b required 00000", i,
                 {awready, wready, bvalid, arready, rvalid});
      end
      checks++;
      if ({bid, bresp, rid, rresp, rlast} !== 13'b0 || rdata !== '0) begin
        errors++;
        $display("FAIL reset_outs cyc%0d: got %h/%h required 0", i,
                 {bid, bresp, rid, rresp, rlast}, rdata);
      end
    end
    areset = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
    #1;
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: awready/arready got %b required 11", {awready, arready});
    end
    tick();
  endtask

  task automatic test_incr();
    logic [IDB-1:0] gb; logic [1:0] gr; int bl, bs, tm, nb, lat, st;
    for (int i = 0; i < 4; i++) begin wb_dat[i] = DB'(32'hA0 + i); wb_strb[i] = '1; end
    do_write(4'h3, 32'h0, 8'd3, INCR, 4, 2, gb, gr, bl, bs, tm);
    checks++;
    if (tm !== 0 || gr !== 2'b00 || gb !== 4'h3) begin
      errors++;
      $display("FAIL incr_b: tmo %0d bresp %0h bid %0h required 0/0/3", tm, gr, gb);
    end
    checks++;
    if (bl !== 1 || bs !== 0) begin
      errors++;
      $display("FAIL incr_b_timing: blat %0d bstall_err %0d required 1/0", bl, bs);
    end
    do_read(4'h5, 32'h0, 8'd3, INCR, 0, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || nb !== 4 || lat !== 2) begin
      errors++;
      $display("FAIL incr_r: tmo %0d beats %0d lat %0d required 0/4/2", tm, nb, lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rb_dat[i] !== DB'(32'hA0 + i) || rb_last[i] !== (i == 3) || rb_id[i] !== 4'h5 ||
          rb_resp[i] !== 2'b00) begin
        errors++;
        $display("FAIL incr_beat%0d: data %0h last %b id %0h resp %0h required %0h/%b/5/0",
                 i, rb_dat[i], rb_last[i], rb_id[i], rb_resp[i], 32'hA0 + i, (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IDB-1:0] gb; logic [1:0] gr; int bl, bs, tm, nb, lat, st;
    for (int i = 0; i < 16; i++) begin wb_dat[i] = DB'(32'h1000 + i); wb_strb[i] = '1; end
    do_write(4'h1, 32'h0, 8'd15, INCR, 16, 0, gb, gr, bl, bs, tm);
    checks++;
    if (tm !== 0 || gr !== 2'b00) begin
      errors++;
      $display("FAIL bp_write: tmo %0d bresp %0h required 0/0", tm, gr);
    end
    do_read(4'hA, 32'h0, 8'd15, INCR, 1, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || nb !== 16 || st !== 0) begin
      errors++;
      $display("FAIL bp_read: tmo %0d beats %0d stall_err %0d required 0/16/0", tm, nb, st);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rb_dat[i] !== DB'(32'h1000 + i) || rb_last[i] !== (i == 15) || rb_id[i] !== 4'hA) begin
        errors++;
        $display("FAIL bp_beat%0d: data %0h last %b id %0h required %0h/%b/a",
                 i, rb_dat[i], rb_last[i], rb_id[i], 32'h1000 + i, (i == 15));
      end
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after: rvalid %b arready %b required 0/1", rvalid, arready);
    end
  endtask

  task automatic test_strobe();
    logic [IDB-1:0] gb; logic [1:0] gr; int bl, bs, tm, nb, lat, st;
    logic [DB-1:0] exp;
    wb_dat[0] = '1; wb_strb[0] = '1;
    do_write(4'h2, 32'h140, 8'd0, INCR, 1, 0, gb, gr, bl, bs, tm);
    wb_dat[0] = DB'(8'h11); wb_strb[0] = SB'(1);
    do_write(4'h2, 32'h140, 8'd0, INCR, 1, 0, gb, gr, bl, bs, tm);
    do_read(4'h2, 32'h140, 8'd0, INCR, 0, nb, lat, st, tm);
    exp = '1;
    exp[7:0] = 8'h11;
    checks++;
    if (tm !== 0 || nb !== 1 || rb_dat[0] !== exp) begin
      errors++;
      $display("FAIL strobe: tmo %0d beats %0d data %h required 0/1/%h", tm, nb, rb_dat[0], exp);
    end
  endtask

  task automatic test_fixed();
    logic [IDB-1:0] gb; logic [1:0] gr; int bl, bs, tm, nb, lat, st;
    for (int i = 0; i < 3; i++) begin wb_dat[i] = DB'(i + 1); wb_strb[i] = '1; end
    do_write(4'h6, 32'h1C0, 8'd2, FIXED, 3, 0, gb, gr, bl, bs, tm);
    checks++;
    if (tm !== 0 || gr !== 2'b00 || gb !== 4'h6) begin
      errors++;
      $display("FAIL fixed_b: tmo %0d bresp %0h bid %0h required 0/0/6", tm, gr, gb);
    end
    do_read(4'h7, 32'h1C0, 8'd0, INCR, 0, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || rb_dat[0] !== DB'(3)) begin
      errors++;
      $display("FAIL fixed_word7: tmo %0d data %0h required 0/3", tm, rb_dat[0]);
    end
    do_read(4'h7, 32'h1C0, 8'd1, FIXED, 0, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || nb !== 2 || rb_dat[0] !== DB'(3) || rb_dat[1] !== DB'(3) || rb_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL fixed_read: beats %0d data %0h,%0h last %b required 2/3,3/1",
               nb, rb_dat[0], rb_dat[1], rb_last[1]);
    end
  endtask

  task automatic test_rw_collision();
    logic [IDB-1:0] gb; logic [1:0] gr; int bl, bs, tm, nb, lat, st, seen;
    logic [DB-1:0] got;
    wb_dat[0] = DB'(8'hAA); wb_strb[0] = '1;
    do_write(4'h0, 32'h240, 8'd0, INCR, 1, 0, gb, gr, bl, bs, tm);
    wr_rd_race(32'h240, DB'(8'hBB), 0, got, seen);
    checks++;
    if (seen !== 1 || got !== DB'(8'hAA)) begin
      errors++;
      $display("FAIL same_cycle_rw: seen %0d data %0h required 1/aa", seen, got);
    end
    do_read(4'h0, 32'h240, 8'd0, INCR, 0, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || rb_dat[0] !== DB'(8'hBB)) begin
      errors++;
      $display("FAIL after_rw: tmo %0d data %0h required 0/bb", tm, rb_dat[0]);
    end
    wr_rd_race(32'h240, DB'(8'hCC), 1, got, seen);
    checks++;
    if (seen !== 1 || got !== DB'(8'hCC)) begin
      errors++;
      $display("FAIL next_cycle_rw: seen %0d data %0h required 1/cc", seen, got);
    end
  endtask

  task automatic test_range();
    int tm, nb, lat, st;
    logic [DB-1:0] exp_dat;
    logic [1:0] exp_resp;
`ifdef AXI_RESP_ERR_EN
    exp_dat = '0;
    exp_resp = 2'b10;
`else
    exp_dat = DB'(32'h1000);
    exp_resp = 2'b00;
`endif
    do_read(4'h9, 32'h10000, 8'd0, INCR, 0, nb, lat, st, tm);
    checks++;
    if (tm !== 0 || nb !== 1 || rb_dat[0] !== exp_dat || rb_resp[0] !== exp_resp || rb_id[0] !== 4'h9) begin
      errors++;
      $display("FAIL range_word1024: beats %0d data %0h resp %0h id %0h required 1/%0h/%0h/9",
               nb, rb_dat[0], rb_resp[0], rb_id[0], exp_dat, exp_resp);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_backpressure();
    test_strobe();
    test_fixed();
    test_rw_collision();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/axi_mem_responder_static.md
Name: axi_mem_responder_static

Overview:
- AXI4 slave endpoint that terminates a static-region AXI4 link in an on-chip memory of DEPTH full-width words.
- Typical placement: at the far end of an AXI register-slice chain, as a test target, scratchpad or config store.
- Read and write channels run independent state machines against a simple dual-port memory (one write port, one read port).
- Supports INCR and FIXED bursts up to 256 beats; byte strobes are honoured.

Parameters:
- ID_BITS, AXI_ID_BITS: width of awid/bid/arid/rid.
- DEPTH, 1024: memory words; power of two, >= 2.
- BASE_ADDR, 0: byte address of word 0; bits below log2(DEPTH*AXI_DATA_BITS/8) are zero.

Ports:
- aclk  input  1  clock; all logic is synchronous to its rising edge.
- areset  input  1  synchronous, active-high reset.
- s_axi  AXI4.s  AXI4 #(.AXI4_ID_BITS(ID_BITS))  slave port.
  - Channels used: AW, W, B, AR, R.
  - awsize/arsize, lock, cache, prot, qos and region are ignored; full-width beats are assumed.

Behaviour:
- Reset:
  - While areset is high: awready, wready, bvalid, arready and rvalid are 0; bid, bresp, rid, rresp, rdata and rlast are 0.
  - Memory contents are not reset.
  - Reset mid-burst aborts the burst with no response. The cycle after areset falls, awready = arready = 1.
- Address mapping: word = (addr - BASE_ADDR) >> log2(AXI_DATA_BITS/8). Low offset bits are ignored, so unaligned addresses are treated as aligned.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, capture id, word address, awlen and awburst, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the current word, with byte lane k written when wstrb[k]=1.
    - INCR: word index increments by 1 and wraps modulo DEPTH.
    - FIXED: word index is held.
    - Beats beyond awlen+1 are not written.
    - The wlast handshake moves the FSM to W_RESP.
  - W_RESP: bvalid=1, bid = captured id, bresp=OKAY. bvalid/bid/bresp are held stable until bready. On the handshake, go to W_IDLE.
  - Latency: wlast handshake at cycle T gives bvalid at T+1. Minimum AW-to-AW spacing is awlen+3 cycles.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, capture id, word address, arlen and arburst, then go to R_BURST.
  - R_BURST: memory reads are issued ahead into a 2-entry output buffer. A read is issued only when a buffer slot will be free.
    - rvalid=1 whenever the buffer is non-empty. rdata/rid/rresp/rlast are stable while rvalid=1 and rready=0.
    - rlast is set on beat arlen+1.
    - After the rlast handshake, go to R_IDLE.
    - Address stepping is the same as for writes.
  - Latency: AR handshake at T gives first rvalid at T+2.
  - Throughput: 1 beat/cycle while rready=1. Backpressure never drops or duplicates a beat.
- Simultaneous events:
  - AW and AR are fully independent.
  - A write and a read to the same word in the same cycle: the read returns the old data (read-first).
  - A write committed at cycle T is visible to a read issued at T+1 or later.
- Only one outstanding transaction per direction; no reordering or interleaving. rid always equals the captured arid.
- WRAP bursts are treated as INCR.

Optional Feature:
- Macro: AXI_RESP_ERR_EN.
- Defined:
  - A burst whose start word or any beat word is >= DEPTH, or whose address is below BASE_ADDR, is an error.
  - Error write: beats are accepted but not stored; bresp=SLVERR.
  - Error read: beats return rdata=0, rresp=SLVERR.
  - A write burst whose wlast arrives early or late relative to awlen+1 also gets bresp=SLVERR.
- Undefined: no range checks; addresses wrap modulo DEPTH; bresp/rresp are always OKAY.

Test Plan:
- Hold areset=1 for 5 cycles with arvalid=awvalid=1 -> no ready or valid asserted; awready=arready=1 in the first cycle after release.
- INCR write at 0x0, awlen=3, data 0xA0..0xA3, all strobes; then INCR read at 0x0, arlen=3 -> bresp=OKAY, bid=awid; rdata=0xA0..0xA3, rlast on the 4th beat only, first rvalid 2 cycles after the AR handshake.
- Write 0xFF..FF to word 5, then write 0x11 with wstrb=0x1 to word 5; read word 5 -> byte0=0x11, bytes 1..63=0xFF.
- 16-beat read at 0x0 with rready toggling 1,0,0,1 -> 16 beats in order, none dropped or duplicated, outputs stable during stalls, rid=arid.
- FIXED write awlen=2, data 1,2,3, to word 7; read word 7 -> 3. In the same cycle, write word 9=0xBB while reading word 9 (old value 0xAA) -> read returns 0xAA; a read one cycle later returns 0xBB.
- With AXI_RESP_ERR_EN, DEPTH=1024: read at word 1024 -> rresp=SLVERR, rdata=0. Without the macro, the same read returns word 0 with OKAY.
